fixed_sat_accum: RTL and testbench

- Parametrised, pipelined, multi-channel saturating fixed-point adder/subtractor/accumulator for the SEA controller datapath.
- Supports per-channel signed accumulators, for example integrator states of several control loops, on one time-shared adder.
- Uses a valid/ready handshake at input and output.
- Each result is saturated to N bits with a per-result overflow flag and per-channel sticky overflow flags.

---
 rtl/fixed_sat_accum_if.sv | 34 +++
 rtl/fixed_sat_accum.sv | 118 +++++++++++
 tb/tb_fixed_sat_accum.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fixed_sat_accum_if.sv
// Handshake and data bundle for fixed_sat_accum: operation request, saturated result, sticky flags.
// The master drives requests and the slave returns results.
interface fixed_sat_accum_if #(
  parameter int P  = 32,
  parameter int Q  = 32,
  parameter int N  = 32,
  parameter int CH = 4
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ch;
  logic [1:0]    in_mode;
  logic [P-1:0]  x;
  logic [Q-1:0]  y;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ch;
  logic [N-1:0]  z;
  logic          ov;
  logic [CH-1:0] ov_sticky;
  logic [CH-1:0] clr_sticky;

  modport master (
    output in_valid, in_ch, in_mode, x, y, out_ready, clr_sticky,
    input  in_ready, out_valid, out_ch, z, ov, ov_sticky
  );

  modport slave (
    input  in_valid, in_ch, in_mode, x, y, out_ready, clr_sticky,
    output in_ready, out_valid, out_ch, z, ov, ov_sticky
  );
endinterface

// File: rtl/fixed_sat_accum.sv
// Two-stage, multi-channel saturating add/sub/accumulate unit sharing one adder.
// Stage 1 registers the operation; stage 2 reads/writes acc[ch], saturates, and registers the result.
module fixed_sat_accum #(
  parameter int P  = 32,
  parameter int Q  = 32,
  parameter int N  = 32,
  parameter int CH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fixed_sat_accum_if.slave bus
);
  localparam int          CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int          MPQ  = (P > Q) ? P : Q;
  localparam int          W    = ((MPQ > N) ? MPQ : N) + 1;
  localparam logic [31:0] CH_U = CH;

  logic                 s1_valid;
  logic [W-1:0]         s1_x;
  logic [W-1:0]         s1_y;
  logic [1:0]           s1_mode;
  logic [CW-1:0]        s1_ch;

  logic [N-1:0]         acc [CH];
  logic                 out_valid_q;
  logic [N-1:0]         z_q;
  logic                 ov_q;
  logic [CW-1:0]        out_ch_q;
  logic [CH-1:0]        sticky_q;

  logic                 advance;
  logic                 accept;
  logic                 fire;
  logic                 ch_ok;
  logic [N-1:0]         acc_rd;
  logic [W-1:0]         acc_w;
  logic [W-1:0]         sum;
  logic                 ov_nxt;
  logic [N-1:0]         z_nxt;
  logic [CH-1:0]        set_mask;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance && rst_n;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = s1_valid && advance;

  // Out-of-range channels (non-power-of-two CH) behave as an empty accumulator and are never written.
  assign ch_ok  = 32'(s1_ch) < CH_U;
  assign acc_rd = ch_ok ? acc[s1_ch] : '0;
  assign acc_w  = {{(W-N){acc_rd[N-1]}}, acc_rd};

  always_comb begin
    sum = '0;
    case (s1_mode)
      2'b00:   sum = s1_x + s1_y;
      2'b01:   sum = s1_x - s1_y;
      2'b10:   sum = acc_w + s1_x;
      default: sum = s1_x;
    endcase
  end

  // Result fits in N bits only when the top W-N+1 bits are all copies of the sign.
  assign ov_nxt = !((&sum[W-1:N-1]) || !(|sum[W-1:N-1]));
  assign z_nxt  = !ov_nxt ? sum[N-1:0]
                : sum[W-1] ? {1'b1, {(N-1){1'b0}}}
                :            {1'b0, {(N-1){1'b1}}};

  always_comb begin
    set_mask = '0;
    for (int c = 0; c < CH; c++) begin
      set_mask[c] = fire && ov_nxt && ch_ok && (32'(s1_ch) == 32'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_x        <= '0;
      s1_y        <= '0;
      s1_mode     <= '0;
      s1_ch       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      ov_q        <= 1'b0;
      out_ch_q    <= '0;
      sticky_q    <= '0;
      for (int c = 0; c < CH; c++) begin
        acc[c] <= '0;
      end
    end else begin
      sticky_q <= (sticky_q & ~bus.clr_sticky) | set_mask;
      if (advance) begin
        s1_valid    <= accept;
        out_valid_q <= s1_valid;
      end
      if (accept) begin
        s1_x    <= {{(W-P){bus.x[P-1]}}, bus.x};
        s1_y    <= {{(W-Q){bus.y[Q-1]}}, bus.y};
        s1_mode <= bus.in_mode;
        s1_ch   <= bus.in_ch;
      end
      if (fire) begin
        z_q      <= z_nxt;
        ov_q     <= ov_nxt;
        out_ch_q <= s1_ch;
        if (s1_mode[1] && ch_ok) begin
          acc[s1_ch] <= z_nxt;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.ov        = ov_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.ov_sticky = sticky_q;
endmodule

// File: tb/tb_fixed_sat_accum.sv
// Directed bench for fixed_sat_accum at P=Q=N=8, CH=4: add/sub saturation, accumulate,
// backpressure, load with sticky set/clear collision, and reset with operations in flight.
module tb_fixed_sat_accum;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fixed_sat_accum_if #(.P(8), .Q(8), .N(8), .CH(4)) bus ();
  fixed_sat_accum #(.P(8), .Q(8), .N(8), .CH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ez, input logic eov, input logic [1:0] ech);
    chk($sformatf("%s_valid", tag), 32'(bus.out_valid), 32'h1);
    chk($sformatf("%s_z", tag), 32'(bus.z), 32'(ez));
    chk($sformatf("%s_ov", tag), 32'(bus.ov), 32'(eov));
    chk($sformatf("%s_ch", tag), 32'(bus.out_ch), 32'(ech));
  endtask

  task automatic issue(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] xv, input logic [7:0] yv);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_mode  = mode;
    bus.x        = xv;
    bus.y        = yv;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_ch      = '0;
    bus.in_mode    = '0;
    bus.x          = '0;
    bus.y          = '0;
    bus.out_ready  = 1'b1;
    bus.clr_sticky = '0;

    // reset state
    tick(); tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_z", 32'(bus.z), 32'h0);
    chk("rst_sticky", 32'(bus.ov_sticky), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(bus.in_ready), 32'h1);

    // add: 100+27 fits, 100+28 saturates
    issue(2'd0, 2'b00, 8'd100, 8'd27);
    tick();
    issue(2'd0, 2'b00, 8'd100, 8'd28);
    chk("add_latency", 32'(bus.out_valid), 32'h0);
    tick();
    idle();
    chk_out("add1", 8'h7f, 1'b0, 2'd0);
    tick();
    chk_out("add2", 8'h7f, 1'b1, 2'd0);
    chk("add2_sticky", 32'(bus.ov_sticky), 32'h1);
    tick();
    chk("add_drain", 32'(bus.out_valid), 32'h0);

    // sub on ch2: -100-28 fits, -100-29 saturates
    issue(2'd2, 2'b01, 8'h9c, 8'd28);
    tick();
    issue(2'd2, 2'b01, 8'h9c, 8'd29);
    tick();
    idle();
    chk_out("sub1", 8'h80, 1'b0, 2'd2);
    tick();
    chk_out("sub2", 8'h80, 1'b1, 2'd2);
    tick();

    // accumulate 50 four times on ch1, then read ch2 via acc+0
    issue(2'd1, 2'b10, 8'd50, 8'd0);
    tick();
    tick();
    chk_out("acc1", 8'd50, 1'b0, 2'd1);
    tick();
    chk_out("acc2", 8'd100, 1'b0, 2'd1);
    tick();
    chk_out("acc3", 8'h7f, 1'b1, 2'd1);
    issue(2'd2, 2'b10, 8'd0, 8'd0);
    tick();
    idle();
    chk_out("acc4", 8'h7f, 1'b1, 2'd1);
    tick();
    chk_out("acc_ch2", 8'd0, 1'b0, 2'd2);
    tick();

    // backpressure: three +1 accumulates on ch0, stall 3 cycles after the first result
    issue(2'd0, 2'b10, 8'd1, 8'd0);
    tick();
    tick();
    chk_out("bp1", 8'd1, 1'b0, 2'd0);
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d_z", i), 32'(bus.z), 32'h1);
      chk($sformatf("bp_hold%0d_rdy", i), 32'(bus.in_ready), 32'h0);
      chk($sformatf("bp_hold%0d_v", i), 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    tick();
    idle();
    chk_out("bp2", 8'd2, 1'b0, 2'd0);
    tick();
    chk_out("bp3", 8'd3, 1'b0, 2'd0);
    tick();
    chk("bp_drain", 32'(bus.out_valid), 32'h0);
    issue(2'd0, 2'b10, 8'd0, 8'd0);
    tick();
    idle();
    tick();
    chk_out("bp_acc0", 8'd3, 1'b0, 2'd0);
    tick();

    // load and accumulate on ch3, then sticky set/clear collision
    chk("pre_sticky", 32'(bus.ov_sticky), 32'h7);
    issue(2'd3, 2'b11, 8'hfb, 8'd0);
    tick();
    issue(2'd3, 2'b10, 8'hfd, 8'd0);
    tick();
    idle();
    chk_out("ld1", 8'hfb, 1'b0, 2'd3);
    tick();
    chk_out("ld2", 8'hf8, 1'b0, 2'd3);
    issue(2'd3, 2'b11, 8'h80, 8'd0);
    tick();
    issue(2'd3, 2'b10, 8'hff, 8'd0);
    tick();
    idle();
    chk_out("ld3", 8'h80, 1'b0, 2'd3);
    bus.clr_sticky = 4'b1000;
    tick();
    bus.clr_sticky = 4'b0000;
    chk_out("ld4", 8'h80, 1'b1, 2'd3);
    chk("set_wins", 32'(bus.ov_sticky), 32'hf);
    bus.clr_sticky = 4'b1000;
    tick();
    bus.clr_sticky = 4'b0000;
    chk("clr3", 32'(bus.ov_sticky), 32'h7);

    // reset with two operations in the pipe and acc[1]=40
    issue(2'd1, 2'b11, 8'd40, 8'd0);
    tick();
    issue(2'd1, 2'b10, 8'd1, 8'd0);
    tick();
    issue(2'd1, 2'b10, 8'd2, 8'd0);
    tick();
    chk_out("rm_pre", 8'd41, 1'b0, 2'd1);
    rst_n = 1'b0;
    idle();
    tick();
    chk("rm_valid", 32'(bus.out_valid), 32'h0);
    chk("rm_sticky", 32'(bus.ov_sticky), 32'h0);
    chk("rm_z", 32'(bus.z), 32'h0);
    chk("rm_in_ready", 32'(bus.in_ready), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rm_no_ghost", 32'(bus.out_valid), 32'h0);
    issue(2'd1, 2'b10, 8'd5, 8'd0);
    tick();
    issue(2'd3, 2'b10, 8'd0, 8'd0);
    tick();
    idle();
    chk_out("rm_acc1", 8'd5, 1'b0, 2'd1);
    tick();
    chk_out("rm_acc3", 8'd0, 1'b0, 2'd3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
